// File: rtl/a5_burst_controller.sv
// Burst sequencer around the A5 keystream stage: loads {frame, key}, runs warm-up,
// streams a 114-bit chunk through the cipher MSB-first and collects the ciphertext.
//   state  | meaning
//   IDLE   | waiting for a chunk, frame counter loadable
//   LOAD   | cipher_reset strobe, seq presented to the cipher
//   WARMUP | discarded mixing clocks
//   STREAM | plaintext out, ciphertext in
//   DRAIN  | capture last ciphertext bit
//   DONE   | result held until consumer accepts
module a5_burst_controller #(
    parameter int FRAMENUMLEN = 22,
    parameter int KEYLEN      = 64,
    parameter int CHUNKLEN    = 114,
    parameter int WARMUP      = 100,
    parameter int CNTLEN      = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [KEYLEN-1:0]             key_i,
    input  logic                          frame_load_i,
    input  logic [FRAMENUMLEN-1:0]        frame_init_i,
    input  logic [CHUNKLEN-1:0]           chunk_in_i,
    input  logic                          chunk_valid_i,
    output logic                          chunk_ready_o,
    output logic [FRAMENUMLEN+KEYLEN-1:0] seq_o,
    output logic                          cipher_reset_o,
    output logic                          cipher_control_o,
    output logic                          cipher_in_o,
    input  logic                          cipher_out_i,
    output logic [CHUNKLEN-1:0]           result_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [FRAMENUMLEN-1:0]        frame_num_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CNTLEN-1:0] WARM_LAST   = CNTLEN'(WARMUP - 1);
    localparam logic [CNTLEN-1:0] STREAM_LAST = CNTLEN'(CHUNKLEN - 1);

    logic [2:0]             state_q, state_d;
    logic [CNTLEN-1:0]      cnt_q, cnt_d;
    logic [FRAMENUMLEN-1:0] frame_q, frame_d;
    logic [KEYLEN-1:0]      key_q, key_d;
    logic [CHUNKLEN-1:0]    shift_q, shift_d;
    logic [CHUNKLEN-1:0]    result_q, result_d;
    logic                   chunk_ready_q, chunk_ready_d;
    logic                   result_valid_q, result_valid_d;
    logic                   cipher_reset_q, cipher_reset_d;
    logic                   cipher_control_q, cipher_control_d;
    logic                   cipher_in_q, cipher_in_d;

    // Registered outputs are computed from the next state, so each phase's
    // drive values are already in place on the first cycle of that phase.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        frame_d          = frame_q;
        key_d            = key_q;
        shift_d          = shift_q;
        result_d         = result_q;
        chunk_ready_d    = 1'b0;
        result_valid_d   = 1'b0;
        cipher_reset_d   = 1'b0;
        cipher_control_d = 1'b0;
        cipher_in_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                chunk_ready_d = 1'b1;
                if (frame_load_i) begin
                    frame_d = frame_init_i;
                end
                if (chunk_valid_i && chunk_ready_q) begin
                    shift_d        = chunk_in_i;
                    key_d          = key_i;
                    chunk_ready_d  = 1'b0;
                    cipher_reset_d = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    cnt_d            = '0;
                    cipher_control_d = 1'b1;
                    cipher_in_d      = shift_q[CHUNKLEN-1];
                    shift_d          = {shift_q[CHUNKLEN-2:0], 1'b0};
                    state_d          = S_STREAM;
                end else begin
                    cnt_d = cnt_q + CNTLEN'(1);
                end
            end
            S_STREAM: begin
                // The first capture here is the pipeline-fill bit; it falls
                // off the top after the full 115 shifts.
                result_d         = {result_q[CHUNKLEN-2:0], cipher_out_i};
                cipher_control_d = 1'b1;
                if (cnt_q == STREAM_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d       = cnt_q + CNTLEN'(1);
                    cipher_in_d = shift_q[CHUNKLEN-1];
                    shift_d     = {shift_q[CHUNKLEN-2:0], 1'b0};
                end
            end
            S_DRAIN: begin
                result_d       = {result_q[CHUNKLEN-2:0], cipher_out_i};
                result_valid_d = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (result_ready_i) begin
                    frame_d       = frame_q + FRAMENUMLEN'(1);
                    chunk_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            frame_q          <= '0;
            key_q            <= '0;
            shift_q          <= '0;
            result_q         <= '0;
            chunk_ready_q    <= 1'b0;
            result_valid_q   <= 1'b0;
            cipher_reset_q   <= 1'b1;
            cipher_control_q <= 1'b0;
            cipher_in_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            frame_q          <= frame_d;
            key_q            <= key_d;
            shift_q          <= shift_d;
            result_q         <= result_d;
            chunk_ready_q    <= chunk_ready_d;
            result_valid_q   <= result_valid_d;
            cipher_reset_q   <= cipher_reset_d;
            cipher_control_q <= cipher_control_d;
            cipher_in_q      <= cipher_in_d;
        end
    end

    assign chunk_ready_o    = chunk_ready_q;
    assign seq_o            = {frame_q, key_q};
    assign cipher_reset_o   = cipher_reset_q;
    assign cipher_control_o = cipher_control_q;
    assign cipher_in_o      = cipher_in_q;
    assign result_o         = result_q;
    assign result_valid_o   = result_valid_q;
    assign frame_num_o      = frame_q;

endmodule

// File: tb/tb_a5_burst_controller.sv
// Bench for a5_burst_controller: an A5/1-style cipher model closes the loop and a
// frame/keystream reference predicts every ciphertext burst.
module tb_a5_burst_controller;

    localparam int FL = 22;
    localparam int KL = 64;
    localparam int CL = 114;
    localparam int WU = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic [KL-1:0] key;
    logic          frame_load;
    logic [FL-1:0] frame_init;
    logic [CL-1:0] chunk_in;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [FL+KL-1:0] seq;
    logic          cipher_reset;
    logic          cipher_control;
    logic          cipher_in;
    logic          cipher_out = 1'b0;
    logic [CL-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic [FL-1:0] frame_num;

    int errors = 0;
    int checks = 0;

    a5_burst_controller dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .key_i           (key),
        .frame_load_i    (frame_load),
        .frame_init_i    (frame_init),
        .chunk_in_i      (chunk_in),
        .chunk_valid_i   (chunk_valid),
        .chunk_ready_o   (chunk_ready),
        .seq_o           (seq),
        .cipher_reset_o  (cipher_reset),
        .cipher_control_o(cipher_control),
        .cipher_in_o     (cipher_in),
        .cipher_out_i    (cipher_out),
        .result_o        (result),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .frame_num_o     (frame_num)
    );

    always #5 clock = ~clock;

    // A5/1 keystream: 64 key clocks, 22 frame clocks, 100 majority warm-up, 114 output bits.
    function automatic logic [CL-1:0] a5_keystream(input logic [FL-1:0] fr, input logic [KL-1:0] ky);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic [CL-1:0] ks;
        logic b, m, all;
        r1 = '0; r2 = '0; r3 = '0; ks = '0;
        for (int i = 0; i < KL + FL + WU + CL; i++) begin
            all = (i < KL + FL);
            b   = (i < KL) ? ky[i] : ((i < KL + FL) ? fr[i-KL] : 1'b0);
            m   = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
            if (all || r1[8] == m)  r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ b};
            if (all || r2[10] == m) r2 = {r2[20:0], r2[20] ^ r2[21] ^ b};
            if (all || r3[10] == m) r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ b};
            if (i >= KL + FL + WU) ks[i-(KL+FL+WU)] = r1[18] ^ r2[21] ^ r3[22];
        end
        return ks;
    endfunction

    // Ciphertext burst: keystream bit i combines with plaintext bit CL-1-i (MSB first).
    function automatic logic [CL-1:0] expect_result(input logic [CL-1:0] ch, input logic [FL-1:0] fr,
                                                    input logic [KL-1:0] ky, input logic g);
        logic [CL-1:0] ks;
        logic [CL-1:0] r;
        ks = g ? a5_keystream(fr, ky) : '0;
        for (int i = 0; i < CL; i++) r[CL-1-i] = ch[CL-1-i] ^ ks[i];
        return r;
    endfunction

    function automatic logic [CL-1:0] rand_chunk();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[CL-1:0];
    endfunction

    // Cipher model: registered out = in ^ gamma; gamma disabled gives a plain 1-cycle loopback.
    logic          gamma_en = 1'b0;
    logic [CL-1:0] ks_q = '0;
    logic [7:0]    ks_idx = '0;
    always @(posedge clock) begin
        if (cipher_reset === 1'b1) begin
            ks_idx     <= '0;
            ks_q       <= gamma_en ? a5_keystream(seq[FL+KL-1:KL], seq[KL-1:0]) : '0;
            cipher_out <= cipher_in;
        end else begin
            cipher_out <= cipher_in ^ ((cipher_control === 1'b1 && ks_idx < 8'(CL)) ? ks_q[ks_idx[6:0]] : 1'b0);
            if (cipher_control === 1'b1) ks_idx <= ks_idx + 8'd1;
        end
    end

    logic [FL-1:0] model_frame = '0;

    logic          tmo;
    int            rst_cnt, rst_first, ctl_cnt, ctl_first, ctl_last, vcycle;
    logic [FL+KL-1:0] seq_load;
    logic          seq_stable;
    logic [CL-1:0] res;

    // Offer one chunk, then record per-cycle observations until result_valid rises.
    task automatic run_burst(input logic [CL-1:0] ch, input logic [KL-1:0] ky,
                             input logic fl, input logic [FL-1:0] fi);
        int w;
        tmo = 1'b0; rst_cnt = 0; rst_first = -1; ctl_cnt = 0; ctl_first = -1; ctl_last = -1;
        vcycle = -1; seq_stable = 1'b1; seq_load = '0; res = '0;
        w = 0;
        while (chunk_ready !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (chunk_ready !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        chunk_in = ch; key = ky; frame_load = fl; frame_init = fi; chunk_valid = 1'b1;
        if (fl) model_frame = fi;
        @(negedge clock);
        chunk_valid = 1'b0; frame_load = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (c == 1) seq_load = seq;
            else if (seq !== seq_load) seq_stable = 1'b0;
            if (cipher_reset === 1'b1) begin
                rst_cnt++;
                if (rst_first < 0) rst_first = c;
            end
            if (cipher_control === 1'b1) begin
                ctl_cnt++;
                if (ctl_first < 0) ctl_first = c;
                ctl_last = c;
            end
            if (result_valid === 1'b1) begin
                vcycle = c;
                res = result;
                return;
            end
            @(negedge clock);
        end
        tmo = 1'b1;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        model_frame = model_frame + FL'(1);
    endtask

    task automatic test_reset();
        reset = 1'b0; chunk_valid = 1'b0; result_ready = 1'b0; frame_load = 1'b0;
        key = '0; chunk_in = '0; frame_init = '0; gamma_en = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (cipher_reset !== 1'b1 || result_valid !== 1'b0 || frame_num !== '0 || chunk_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got crst=%b rv=%b fn=%0h rdy=%b exp crst=1 rv=0 fn=0 rdy=0",
                         cipher_reset, result_valid, frame_num, chunk_ready);
            end
        end
        reset = 1'b1;
        model_frame = '0;
        @(negedge clock);
        checks++;
        if (chunk_ready !== 1'b1 || cipher_reset !== 1'b0 || seq !== '0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b crst=%b seq=%0h exp rdy=1 crst=0 seq=0",
                     chunk_ready, cipher_reset, seq);
        end
    endtask

    task automatic test_latency();
        logic [KL-1:0] ky;
        logic [CL-1:0] ch;
        ky = 64'h1234_5678_9ABC_DEF0;
        ch = rand_chunk();
        gamma_en = 1'b0;
        run_burst(ch, ky, 1'b1, 22'h134);
        checks++;
        if (tmo !== 1'b0) begin errors++; $display("FAIL lat_timeout: got tmo=%b exp 0", tmo); end
        checks++;
        if (seq_load !== {22'h134, ky}) begin errors++; $display("FAIL lat_seq: got %h exp %h", seq_load, {22'h134, ky}); end
        checks++;
        if (rst_cnt != 1 || rst_first != 1) begin
            errors++; $display("FAIL lat_reset_pulse: got cnt=%0d first=%0d exp cnt=1 first=1", rst_cnt, rst_first);
        end
        checks++;
        if (ctl_first - rst_first - 1 != WU) begin
            errors++; $display("FAIL lat_warmup_len: got %0d exp %0d", ctl_first - rst_first - 1, WU);
        end
        checks++;
        if (ctl_cnt != CL + 1 || ctl_last - ctl_first + 1 != ctl_cnt) begin
            errors++; $display("FAIL lat_stream_len: got cnt=%0d span=%0d exp %0d", ctl_cnt, ctl_last - ctl_first + 1, CL + 1);
        end
        checks++;
        if (vcycle != WU + CL + 3) begin errors++; $display("FAIL lat_valid_cycle: got %0d exp %0d", vcycle, WU + CL + 3); end
        checks++;
        if (seq_stable !== 1'b1) begin errors++; $display("FAIL lat_seq_stable: got %b exp 1", seq_stable); end
        checks++;
        if (res !== ch) begin errors++; $display("FAIL lat_loopback: got %h exp %h", res, ch); end
        handshake();
        checks++;
        if (frame_num !== model_frame || chunk_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_after_hs: got fn=%0h rdy=%b rv=%b exp fn=%0h rdy=1 rv=0", frame_num, chunk_ready, result_valid, model_frame);
        end
    endtask

    task automatic test_loopback();
        logic [CL-1:0] pats [4];
        logic [CL-1:0] alt;
        logic [KL-1:0] ky;
        for (int i = 0; i < CL; i++) alt[i] = (i % 2 == 1);
        pats[0] = alt; pats[1] = '1; pats[2] = rand_chunk(); pats[3] = rand_chunk();
        gamma_en = 1'b0;
        for (int p = 0; p < 4; p++) begin
            ky = {$urandom, $urandom};
            run_burst(pats[p], ky, 1'b0, '0);
            checks++;
            if (tmo !== 1'b0 || res !== pats[p]) begin
                errors++; $display("FAIL loopback_%0d: got %h tmo=%b exp %h", p, res, tmo, pats[p]);
            end
            handshake();
            checks++;
            if (frame_num !== model_frame) begin
                errors++; $display("FAIL loopback_frame_%0d: got %0h exp %0h", p, frame_num, model_frame);
            end
        end
    endtask

    task automatic test_known_gamma();
        logic [KL-1:0] ky;
        logic [CL-1:0] ch, ex;
        logic [FL-1:0] fi;
        logic fl;
        gamma_en = 1'b1;
        ky = 64'h1234_5678_9ABC_DEF0;
        run_burst('0, ky, 1'b1, 22'h134);
        ex = expect_result('0, 22'h134, ky, 1'b1);
        checks++;
        if (tmo !== 1'b0 || res !== ex) begin errors++; $display("FAIL gamma_known: got %h tmo=%b exp %h", res, tmo, ex); end
        handshake();
        for (int n = 0; n < 3; n++) begin
            ky = {$urandom, $urandom};
            ch = rand_chunk();
            fi = FL'($urandom);
            fl = 1'($urandom_range(0, 1));
            run_burst(ch, ky, fl, fi);
            ex = expect_result(ch, model_frame, ky, 1'b1);
            checks++;
            if (tmo !== 1'b0 || res !== ex) begin errors++; $display("FAIL gamma_rand_%0d: got %h tmo=%b exp %h", n, res, tmo, ex); end
            handshake();
            checks++;
            if (frame_num !== model_frame) begin
                errors++; $display("FAIL gamma_frame_%0d: got %0h exp %0h", n, frame_num, model_frame);
            end
        end
    endtask

    task automatic test_backpressure_wrap();
        logic [KL-1:0] ky;
        logic [CL-1:0] ch, ex, held;
        int bad;
        gamma_en = 1'b1;
        ky = {$urandom, $urandom};
        ch = rand_chunk();
        run_burst(ch, ky, 1'b1, 22'h3FFFFF);
        ex = expect_result(ch, 22'h3FFFFF, ky, 1'b1);
        checks++;
        if (tmo !== 1'b0 || res !== ex) begin errors++; $display("FAIL bp_result: got %h tmo=%b exp %h", res, tmo, ex); end
        held = res;
        bad = 0;
        for (int s = 0; s < 50; s++) begin
            frame_load = (s % 7 == 3); frame_init = FL'($urandom);
            @(negedge clock);
            checks++;
            if (result !== held || chunk_ready !== 1'b0 || result_valid !== 1'b1) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL bp_stall_%0d: got res=%h rdy=%b rv=%b exp res=%h rdy=0 rv=1",
                                      s, result, chunk_ready, result_valid, held);
            end
        end
        frame_load = 1'b0;
        checks++;
        if (frame_num !== 22'h3FFFFF) begin errors++; $display("FAIL bp_frame_ignored: got %0h exp 3fffff", frame_num); end
        handshake();
        checks++;
        if (frame_num !== '0 || frame_num !== model_frame) begin
            errors++; $display("FAIL bp_wrap: got %0h exp %0h", frame_num, model_frame);
        end
        ch = rand_chunk();
        run_burst(ch, ky, 1'b0, '0);
        ex = expect_result(ch, '0, ky, 1'b1);
        checks++;
        if (seq_load[FL+KL-1:KL] !== '0 || res !== ex) begin
            errors++; $display("FAIL bp_next_burst: got frame=%0h res=%h exp frame=0 res=%h", seq_load[FL+KL-1:KL], res, ex);
        end
        handshake();
    endtask

    task automatic test_reset_mid_burst();
        logic [KL-1:0] ky;
        logic [CL-1:0] ch, ex;
        logic seen;
        int w;
        gamma_en = 1'b1;
        ky = {$urandom, $urandom};
        w = 0;
        while (chunk_ready !== 1'b1 && w < 20) begin @(negedge clock); w++; end
        chunk_in = rand_chunk(); key = ky; frame_load = 1'b1; frame_init = FL'($urandom_range(1, 4000));
        chunk_valid = 1'b1;
        @(negedge clock);
        chunk_valid = 1'b0; frame_load = 1'b0;
        repeat (41) @(negedge clock);
        checks++;
        if (cipher_control !== 1'b0 || cipher_reset !== 1'b0 || seq[FL+KL-1:KL] !== frame_init) begin
            errors++; $display("FAIL mid_in_warmup: got ctl=%b crst=%b frame=%0h exp ctl=0 crst=0 frame=%0h",
                               cipher_control, cipher_reset, seq[FL+KL-1:KL], frame_init);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (cipher_reset !== 1'b1 || result_valid !== 1'b0 || cipher_control !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hold: got crst=%b rv=%b ctl=%b exp crst=1 rv=0 ctl=0", cipher_reset, result_valid, cipher_control);
        end
        reset = 1'b1;
        model_frame = '0;
        seen = 1'b0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clock);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || frame_num !== '0) begin
            errors++; $display("FAIL mid_aborted: got rv_seen=%b fn=%0h exp rv_seen=0 fn=0", seen, frame_num);
        end
        ch = rand_chunk();
        run_burst(ch, ky, 1'b0, '0);
        ex = expect_result(ch, model_frame, ky, 1'b1);
        checks++;
        if (tmo !== 1'b0 || res !== ex || vcycle != WU + CL + 3) begin
            errors++; $display("FAIL mid_recover: got %h cyc=%0d tmo=%b exp %h cyc=%0d", res, vcycle, tmo, ex, WU + CL + 3);
        end
        handshake();
        checks++;
        if (frame_num !== 22'd1) begin errors++; $display("FAIL mid_frame_after: got %0h exp 1", frame_num); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_loopback();
        test_known_gamma();
        test_backpressure_wrap();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a5_burst_controller.md
Name: a5_burst_controller

Overview:
- Sits around the A5 keystream cipher stage and sequences one GSM burst per request.
- Accepts a 114-bit plaintext chunk and latches the 64-bit key. Drives the cipher's seq/reset/control/in for load, warm-up and stream phases.
- Serially feeds plaintext into the cipher and deserialises the cipher output back into a 114-bit ciphertext chunk.
- Keeps the 22-bit frame counter, which increments per burst.

Parameters:
FRAMENUMLEN, 22, frame counter width
KEYLEN, 64, session key width
CHUNKLEN, 114, burst payload bits
WARMUP, 100, discarded mixing clocks between load and stream
CNTLEN, 8, phase counter width; must satisfy 2^CNTLEN > max(WARMUP, CHUNKLEN)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low
key  in  KEYLEN  session key, sampled on chunk acceptance
frame_load  in  1  load frame_init into frame counter (honoured in IDLE only)
frame_init  in  FRAMENUMLEN  frame counter load value
chunk_in  in  CHUNKLEN  plaintext burst
chunk_valid  in  1  chunk_in valid
chunk_ready  out  1  controller can accept a chunk
seq  out  FRAMENUMLEN+KEYLEN  {frame_cnt, key_reg} to the cipher
cipher_reset  out  1  active-high reset/load strobe to the cipher
cipher_control  out  1  cipher output enable
cipher_in  out  1  serial plaintext bit to the cipher
cipher_out  in  1  serial ciphertext bit from the cipher
result  out  CHUNKLEN  ciphertext burst
result_valid  out  1  result holds a complete burst
result_ready  in  1  consumer accepts result
frame_num  out  FRAMENUMLEN  current frame counter

Behaviour:
- All outputs are registered.
- While reset=0 at a clock edge, the following apply:
  - state=IDLE, frame_cnt=0, key_reg=0, shift and capture registers=0.
  - result_valid=0, chunk_ready=0, cipher_control=0, cipher_in=0, cipher_reset=1.
- The first edge with reset=1 leaves chunk_ready=1 from the next cycle.
- Reset taken mid-burst aborts the burst: no result, and frame_cnt returns to 0.
- FSM states: IDLE, LOAD, WARMUP, STREAM, DRAIN, DONE.
- IDLE:
  - chunk_ready=1 and cipher_reset=0.
  - If frame_load=1, frame_cnt<=frame_init.
  - On chunk_valid&chunk_ready: chunk_in goes into the shift register, key goes into key_reg, chunk_ready<=0, and the FSM goes to LOAD.
  - If frame_load and chunk acceptance coincide, the burst uses frame_init.
  - frame_load is ignored outside IDLE.
- LOAD (1 cycle): cipher_reset=1, cipher_control=0, seq stable. Goes to WARMUP.
- WARMUP (exactly WARMUP cycles): cipher_reset=0 and cipher_control=0. The phase counter counts 0..WARMUP-1, then the FSM goes to STREAM.
- STREAM (exactly CHUNKLEN cycles):
  - cipher_control=1.
  - Cycle k drives cipher_in = chunk bit CHUNKLEN-1-k (MSB first).
  - cipher_out is sampled one cycle after the corresponding drive. The first sample, in STREAM cycle 1, is discarded as the pipeline fill.
  - Captured bits shift into result from the LSB, so the first ciphertext bit ends at bit CHUNKLEN-1.
- DRAIN (1 cycle): cipher_control=1 and cipher_in=0. Captures the final ciphertext bit.
- DONE:
  - result_valid=1 with result stable, and cipher_control=0.
  - On result_ready=1: result_valid<=0, frame_cnt<=frame_cnt+1 modulo 2^FRAMENUMLEN (0x3FFFFF wraps to 0), and the FSM goes to IDLE.
  - result_ready outside DONE is ignored.
- Latency with acceptance at edge 0:
  - LOAD at cycle 1, WARMUP cycles 2..WARMUP+1, STREAM cycles WARMUP+2..WARMUP+CHUNKLEN+1, DRAIN at WARMUP+CHUNKLEN+2.
  - result_valid rises at cycle WARMUP+CHUNKLEN+3 (217 at defaults).
- The earliest next acceptance is the cycle after the DONE handshake.
- seq always equals {frame_cnt, key_reg}; it changes only in IDLE or at the DONE handshake.
- frame_num mirrors frame_cnt.

Test Plan:
- Reset and idle: hold reset=0 for 3 clocks, then release. Required: cipher_reset=1 during reset, result_valid=0, frame_num=0; chunk_ready=1 on the first cycle after release.
- Latency and key/frame load: frame_load=1 with frame_init=0x134, key=0x12345678_9ABCDEF0, and chunk_valid in the same cycle. Required:
  - seq={22'h134, key}.
  - cipher_reset pulses for exactly 1 cycle.
  - cipher_control=0 for exactly 100 cycles, then 1 for 115 cycles.
  - result_valid rises 217 cycles after acceptance.
- Loopback zero-gamma: cipher_out is driven from a 1-cycle registered copy of cipher_in; chunk_in=114'h2AAAA...A. Required: result==chunk_in. Repeat with an all-ones chunk.
- Known gamma: cipher_out is the cipher model output over {frame 0x134, key above} with an all-zero chunk. Required: result equals the reference keystream bits 0..113 placed MSB-first.
- Backpressure and wrap: frame_init=0x3FFFFF; hold result_ready=0 for 50 cycles. Required:
  - result stable and chunk_ready=0 while stalled.
  - After the handshake, frame_num=0 and the next burst's seq upper bits =0.
- Reset mid-burst: assert reset=0 in WARMUP cycle 40. Required: result_valid never rises, frame_num=0, and a new chunk is accepted normally after release.
